avalon_st_enforcer_v2: RTL and testbench

Parametrised, fully registered successor to the single-channel Avalon-ST enforcer. Sits between an untrusted Avalon-ST source and trusted downstream logic. Guarantees well-formed packets on the output:
- drops orphan words
- resolves SOP-inside-packet per a policy parameter
- truncates over-long packets
- keeps saturating error counters
Full valid/rdy backpressure through a one-entry output register slice.

---
 rtl/avalon_enforcer_pkg.sv | 14 +
 rtl/avalon_st_if.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/avalon_st_enforcer_v2.sv | 211 +++++++++++++++++++++
 tb/tb_avalon_st_enforcer_v2.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_enforcer_pkg.sv
// Shared types for the Avalon-ST enforcer: FSM state encoding and SOP policy selectors.
package avalon_enforcer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IN_PKT    = 2'd1,
    TERMINATE = 2'd2,
    DISCARD   = 2'd3
  } state_t;

  localparam int SOP_POLICY_TERMINATE = 0;
  localparam int SOP_POLICY_IGNORE    = 1;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data/valid/sop/eop/empty flow forward, rdy flows back.
interface avalon_st_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/avalon_st_enforcer_v2.sv
// Avalon-ST enforcer: turns an untrusted stream into well-formed packets behind a
// one-entry output register slice (forwarded words appear one cycle after accept).
module avalon_st_enforcer_v2
  import avalon_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
  parameter int MAX_PKT_WORDS = 256,
  parameter int SOP_POLICY    = SOP_POLICY_TERMINATE,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.slave           untrusted,
  avalon_st_if.master          enforced,
  output logic                 err_orphan,
  output logic                 err_nested_sop,
  output logic                 err_trunc,
  output logic [CNT_WIDTH-1:0] orphan_cnt,
  output logic [CNT_WIDTH-1:0] nested_sop_cnt,
  output logic [CNT_WIDTH-1:0] trunc_cnt,
  output logic                 in_packet
);

  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [CW-1:0]          w_cnt_inc;

  logic                   r_vld;
  logic                   r_sop;
  logic                   r_eop;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [EMPTY_WIDTH-1:0] r_empty;
  logic                   r_err_orphan;
  logic                   r_err_nested;
  logic                   r_err_trunc;

  logic                   w_slot_free;
  logic                   w_sop_hazard;
  logic                   w_rdy;
  logic                   w_accept;
  logic                   w_as_idle;
  logic                   w_load;
  logic                   w_ld_sop;
  logic                   w_ld_eop;
  logic [DATA_WIDTH-1:0]  w_ld_data;
  logic [EMPTY_WIDTH-1:0] w_ld_empty;
  logic                   w_orphan;
  logic                   w_nested;
  logic                   w_trunc;

  assign w_slot_free = ~r_vld | enforced.rdy;

  // Under TERMINATE policy a stray SOP must not be consumed until the open packet is closed.
  assign w_sop_hazard = (SOP_POLICY == SOP_POLICY_TERMINATE) && (r_state == IN_PKT)
                        && untrusted.valid && untrusted.sop;
  assign w_rdy        = w_slot_free && (r_state != TERMINATE) && !w_sop_hazard;
  assign w_accept     = untrusted.valid && w_rdy;
  assign w_as_idle    = (r_state == IDLE) || ((r_state == DISCARD) && untrusted.sop);
  assign w_cnt_inc    = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DISCARD: begin
        if (w_load) begin
          w_state_nxt = w_trunc ? DISCARD : (w_ld_eop ? IDLE : IN_PKT);
        end else if ((r_state == DISCARD) && w_accept && untrusted.eop) begin
          w_state_nxt = IDLE;
        end
      end
      IN_PKT: begin
        if (w_sop_hazard) begin
          w_state_nxt = TERMINATE;
        end else if (w_load && w_ld_eop) begin
          w_state_nxt = w_trunc ? DISCARD : IDLE;
        end
      end
      TERMINATE: begin
        if (w_slot_free) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_ld_sop   = 1'b0;
    w_ld_eop   = 1'b0;
    w_ld_data  = untrusted.data;
    w_ld_empty = '0;
    w_orphan   = 1'b0;
    w_trunc    = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_nested   = w_sop_hazard || ((r_state == IN_PKT) && w_accept && untrusted.sop);

    if (r_state == TERMINATE) begin
      // Synthetic closing word for the packet interrupted by a stray SOP.
      if (w_slot_free) begin
        w_load     = 1'b1;
        w_ld_data  = '0;
        w_ld_eop   = 1'b1;
        w_ld_empty = '1;
      end
    end else if (w_accept) begin
      if (w_as_idle) begin
        if (untrusted.sop) begin
          w_load    = 1'b1;
          w_ld_sop  = 1'b1;
          w_cnt_nxt = CW'(1);
          if (untrusted.eop) begin
            w_ld_eop   = 1'b1;
            w_ld_empty = untrusted.empty;
          end else if (MAX_PKT_WORDS == 1) begin
            w_ld_eop = 1'b1;
            w_trunc  = 1'b1;
          end
        end else begin
          w_orphan = (r_state == IDLE);
        end
      end else if (r_state == IN_PKT) begin
        // Continuation word; any SOP reaching here is a stray one under IGNORE policy.
        w_load    = 1'b1;
        w_cnt_nxt = w_cnt_inc;
        if (untrusted.eop) begin
          w_ld_eop   = 1'b1;
          w_ld_empty = untrusted.empty;
        end else if (w_cnt_inc == CW'(MAX_PKT_WORDS)) begin
          w_ld_eop = 1'b1;
          w_trunc  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld        <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_data       <= '0;
      r_empty      <= '0;
      r_err_orphan <= 1'b0;
      r_err_nested <= 1'b0;
      r_err_trunc  <= 1'b0;
    end else begin
      if (w_slot_free) begin
        r_vld <= w_load;
        if (w_load) begin
          r_data  <= w_ld_data;
          r_sop   <= w_ld_sop;
          r_eop   <= w_ld_eop;
          r_empty <= w_ld_empty;
        end
      end
      r_err_orphan <= w_orphan;
      r_err_nested <= w_nested;
      r_err_trunc  <= w_trunc;
    end
  end

  assign untrusted.rdy  = w_rdy;
  assign enforced.valid = r_vld;
  assign enforced.sop   = r_sop;
  assign enforced.eop   = r_eop;
  assign enforced.data  = r_data;
  assign enforced.empty = r_empty;

  assign err_orphan     = r_err_orphan;
  assign err_nested_sop = r_err_nested;
  assign err_trunc      = r_err_trunc;
  assign in_packet      = (r_state == IN_PKT) || (r_state == TERMINATE);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_orphan_cnt (
    .clk (clk),
    .rst (rst),
    .inc (r_err_orphan),
    .cnt (orphan_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_nested_cnt (
    .clk (clk),
    .rst (rst),
    .inc (r_err_nested),
    .cnt (nested_sop_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_trunc_cnt (
    .clk (clk),
    .rst (rst),
    .inc (r_err_trunc),
    .cnt (trunc_cnt)
  );

endmodule

// File: tb/tb_avalon_st_enforcer_v2.sv
// Bench: three enforcers (TERMINATE/max4, IGNORE/max4, TERMINATE/max1) share each stimulus
// stream; outputs are scored against a word-sequence reference model.
module tb_avalon_st_enforcer_v2;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } word_t;

  localparam int LIMIT = 3000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  word_t      i_word [3];
  logic [2:0] i_vld;
  logic [2:0] i_rdy;
  logic [2:0] o_rdy;
  logic [2:0] o_vld;
  word_t      o_word [3];
  logic [2:0] e_orph;
  logic [2:0] e_nest;
  logic [2:0] e_trunc;
  logic [2:0] inpkt;
  logic [1:0] c_orph  [3];
  logic [1:0] c_nest  [3];
  logic [1:0] c_trunc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int POL  = (g == 1) ? 1 : 0;
    localparam int MAXW = (g == 2) ? 1 : 4;

    avalon_st_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) u_in ();
    avalon_st_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2)) u_out ();

    assign u_in.data  = i_word[g].data;
    assign u_in.sop   = i_word[g].sop;
    assign u_in.eop   = i_word[g].eop;
    assign u_in.empty = i_word[g].empty;
    assign u_in.valid = i_vld[g];
    assign i_rdy[g]   = u_in.rdy;
    assign u_out.rdy  = o_rdy[g];
    assign o_vld[g]   = u_out.valid;
    assign o_word[g]  = {u_out.data, u_out.sop, u_out.eop, u_out.empty};

    avalon_st_enforcer_v2 #(
      .DATA_WIDTH    (32),
      .EMPTY_WIDTH   (2),
      .MAX_PKT_WORDS (MAXW),
      .SOP_POLICY    (POL),
      .CNT_WIDTH     (2)
    ) u_dut (
      .clk            (clk),
      .rst            (rst_n),
      .untrusted      (u_in),
      .enforced       (u_out),
      .err_orphan     (e_orph[g]),
      .err_nested_sop (e_nest[g]),
      .err_trunc      (e_trunc[g]),
      .orphan_cnt     (c_orph[g]),
      .nested_sop_cnt (c_nest[g]),
      .trunc_cnt      (c_trunc[g]),
      .in_packet      (inpkt[g])
    );
  end

  word_t stim [$];
  word_t src_q [3][$];
  word_t got_q [3][$];
  word_t exp_q [3][$];
  int    exp_orph [3];
  int    exp_nest [3];
  int    exp_trunc[3];
  bit    exp_open [3];
  int    n_orph   [3];
  int    n_nest   [3];
  int    n_trunc  [3];
  int    first_acc[3];
  int    first_out[3];
  int    cyc;
  int    vld_pct;
  int    rdy_pct;
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic word_t mk(input bit sop, input bit eop);
    word_t w;
    w.data  = $urandom;
    w.sop   = sop;
    w.eop   = eop;
    w.empty = 2'($urandom_range(3));
    return w;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Reference: walk the source word sequence with packet-level rules.
  task automatic model(input int d);
    int    pol  = (d == 1) ? 1 : 0;
    int    maxw = (d == 2) ? 1 : 4;
    bit    open = 0;
    bit    drop = 0;
    int    len  = 0;
    word_t w;
    exp_q[d] = {};
    exp_orph[d] = 0; exp_nest[d] = 0; exp_trunc[d] = 0;
    foreach (stim[i]) begin
      w = stim[i];
      if (open && w.sop) begin
        exp_nest[d]++;
        if (pol == 0) begin
          exp_q[d].push_back({32'd0, 1'b0, 1'b1, 2'b11});
          open = 0;
        end else begin
          w.sop = 1'b0;
        end
      end
      if (open) begin
        len++;
        if (w.eop) begin
          exp_q[d].push_back({w.data, 1'b0, 1'b1, w.empty});
          open = 0;
        end else if (len == maxw) begin
          exp_q[d].push_back({w.data, 1'b0, 1'b1, 2'b00});
          exp_trunc[d]++;
          open = 0; drop = 1;
        end else begin
          exp_q[d].push_back({w.data, 1'b0, 1'b0, 2'b00});
        end
      end else if (w.sop) begin
        drop = 0; len = 1;
        if (w.eop) begin
          exp_q[d].push_back({w.data, 1'b1, 1'b1, w.empty});
        end else if (maxw == 1) begin
          exp_q[d].push_back({w.data, 1'b1, 1'b1, 2'b00});
          exp_trunc[d]++;
          drop = 1;
        end else begin
          exp_q[d].push_back({w.data, 1'b1, 1'b0, 2'b00});
          open = 1;
        end
      end else if (drop) begin
        if (w.eop) drop = 0;
      end else begin
        exp_orph[d]++;
      end
    end
    exp_open[d] = open;
  endtask

  task automatic cycle();
    logic [2:0] acc;
    for (int d = 0; d < 3; d++) begin
      i_vld[d] = (src_q[d].size() > 0) && ($urandom_range(99) < vld_pct);
      if (src_q[d].size() > 0) i_word[d] = src_q[d][0];
      o_rdy[d] = ($urandom_range(99) < rdy_pct);
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      acc[d] = i_vld[d] && i_rdy[d];
      if (acc[d] && first_acc[d] < 0) first_acc[d] = cyc;
      if (o_vld[d] && o_rdy[d]) begin
        got_q[d].push_back(o_word[d]);
        if (first_out[d] < 0) first_out[d] = cyc;
      end
      n_orph[d]  += int'(e_orph[d]);
      n_nest[d]  += int'(e_nest[d]);
      n_trunc[d] += int'(e_trunc[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) if (acc[d]) void'(src_q[d].pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_vld = '0;
    o_rdy = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      got_q[d] = {};
      n_orph[d] = 0; n_nest[d] = 0; n_trunc[d] = 0;
      first_acc[d] = -1; first_out[d] = -1;
    end
    @(negedge clk);
  endtask

  task automatic load_stim();
    for (int d = 0; d < 3; d++) begin
      src_q[d] = stim;
      model(d);
    end
  endtask

  task automatic run_step(input string name);
    int n = 0;
    load_stim();
    while (n < LIMIT && ((src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0 || o_vld != 3'b000)) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk({name, " drained"}, 64'(n < LIMIT), 64'd1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d out_count", name, d), 64'(got_q[d].size()), 64'(exp_q[d].size()));
      for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++)
        chk($sformatf("%s d%0d word%0d", name, d, i), 64'(got_q[d][i]), 64'(exp_q[d][i]));
      chk($sformatf("%s d%0d orphan_pulses", name, d), 64'(n_orph[d]), 64'(exp_orph[d]));
      chk($sformatf("%s d%0d nested_pulses", name, d), 64'(n_nest[d]), 64'(exp_nest[d]));
      chk($sformatf("%s d%0d trunc_pulses", name, d), 64'(n_trunc[d]), 64'(exp_trunc[d]));
      chk($sformatf("%s d%0d orphan_cnt", name, d), 64'(c_orph[d]), 64'(sat3(exp_orph[d])));
      chk($sformatf("%s d%0d nested_cnt", name, d), 64'(c_nest[d]), 64'(sat3(exp_nest[d])));
      chk($sformatf("%s d%0d trunc_cnt", name, d), 64'(c_trunc[d]), 64'(sat3(exp_trunc[d])));
      chk($sformatf("%s d%0d in_packet", name, d), 64'(inpkt[d]), 64'(exp_open[d]));
    end
  endtask

  initial begin
    int n;
    cyc = 0;
    i_vld = '0;
    o_rdy = '0;
    for (int d = 0; d < 3; d++) i_word[d] = '0;

    do_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d outputs", d),
          64'({o_vld[d], o_word[d], e_orph[d], e_nest[d], e_trunc[d], c_orph[d], c_nest[d], c_trunc[d], inpkt[d]}),
          64'd0);
      chk($sformatf("reset d%0d in_rdy", d), 64'(i_rdy[d]), 64'd1);
    end

    // Clean 4-word packet, full throughput.
    vld_pct = 100; rdy_pct = 100;
    stim = {mk(1, 0), mk(0, 0), mk(0, 0), mk(0, 1)};
    run_step("clean");
    chk("clean latency", 64'(first_out[0] - first_acc[0]), 64'd1);

    do_reset();
    stim = {mk(0, 0)};
    run_step("orphan");

    do_reset();
    stim = {mk(1, 0), mk(0, 0), mk(1, 0), mk(0, 0), mk(0, 1)};
    run_step("nested");

    do_reset();
    stim = {mk(1, 0), mk(0, 0), mk(0, 0), mk(0, 0), mk(0, 0), mk(0, 0), mk(0, 1),
            mk(1, 0), mk(0, 1)};
    run_step("trunc");

    do_reset();
    vld_pct = 70; rdy_pct = 50;
    stim = {};
    for (int i = 0; i < 40; i++) stim.push_back(mk($urandom_range(99) < 30, $urandom_range(99) < 30));
    run_step("random");

    do_reset();
    stim = {mk(0, 0), mk(0, 1), mk(0, 0), mk(0, 0), mk(0, 1)};
    run_step("saturate");

    // Reset in the middle of an open packet.
    do_reset();
    stim = {mk(0, 0), mk(1, 0), mk(0, 0), mk(0, 0)};
    load_stim();
    n = 0;
    while (n < LIMIT && (src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    chk("midrst fed", 64'(n < LIMIT), 64'd1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst d%0d orphan_cnt_pre", d), 64'(c_orph[d]), 64'd1);
      chk($sformatf("midrst d%0d prefix_len", d), 64'(got_q[d].size() <= exp_q[d].size()), 64'd1);
      for (int i = 0; i < got_q[d].size() && i < exp_q[d].size(); i++)
        chk($sformatf("midrst d%0d word%0d", d, i), 64'(got_q[d][i]), 64'(exp_q[d][i]));
    end
    chk("midrst d0 in_packet_pre", 64'(inpkt[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("midrst d%0d outputs", d),
          64'({o_vld[d], o_word[d], e_orph[d], e_nest[d], e_trunc[d], c_orph[d], c_nest[d], c_trunc[d], inpkt[d]}),
          64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
